// File: rtl/seven_seg_scan_pkg.sv
// seg_pkg: seven-segment constants and BCD glyph decoder (active-low, a..g = bits 0..6)
package seg_pkg;
  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
    case (v)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return SEG_DASH;
    endcase
  endfunction
endpackage

// File: rtl/seven_seg_scan_tick_gen.sv
// scan_tick_gen: two-flop synchronizer plus rising-edge detector for the divided scan clock
module scan_tick_gen (
  input  logic clk_in,
  input  logic rst_n,
  input  logic i_async,
  output logic o_tick
);
  logic [1:0] r_sync;
  logic       r_hist;
  // synchronize the divider output and keep one cycle of history for edge detection
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_hist <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_async};
      r_hist <= r_sync[1];
    end
  end
  assign o_tick = r_sync[1] & ~r_hist;
endmodule

// File: rtl/seven_seg_scan.sv
// seven_seg_scan: multiplexed seven-segment driver with per-frame snapshot, blanking and blink
module seven_seg_scan
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int BLINK_TICKS = 500
) (
  input  logic                      clk_in,
  input  logic                      rst_n,
  input  logic                      scan_clk,
  input  logic [4*NUM_DIGITS-1:0]   digits_bcd,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic                      blank_lz,
  input  logic [NUM_DIGITS-1:0]     blink_en,
  output logic [NUM_DIGITS-1:0]     an,
  output logic [6:0]                seg,
  output logic                      dp,
  output logic                      frame_done
);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int CW = $clog2(BLINK_TICKS + 1);
  logic                    w_tick, w_wrap, w_last, w_run, w_dark;
  logic [IW-1:0]           r_idx;
  logic [4*NUM_DIGITS-1:0] r_digits;
  logic [NUM_DIGITS-1:0]   r_dp, r_blink, w_lz;
  logic                    r_blank_lz, r_phase, r_upd, r_wrap;
  logic [CW-1:0]           r_cnt;
  logic [3:0]              w_digit;
  scan_tick_gen u_tick (
    .clk_in  (clk_in),
    .rst_n   (rst_n),
    .i_async (scan_clk),
    .o_tick  (w_tick)
  );
  assign w_wrap = w_tick && (r_idx == IW'(NUM_DIGITS - 1));
  assign w_last = r_cnt == CW'(BLINK_TICKS - 1);
  // scan index, blink timebase and frame snapshot advance only on scan ticks
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      r_idx      <= IW'(NUM_DIGITS - 1);
      r_digits   <= '0;
      r_dp       <= '0;
      r_blink    <= '0;
      r_blank_lz <= 1'b0;
      r_cnt      <= '0;
      r_phase    <= 1'b0;
      r_upd      <= 1'b0;
      r_wrap     <= 1'b0;
    end else begin
      r_upd  <= w_tick;
      r_wrap <= w_wrap;
      if (w_tick) begin
        r_idx   <= w_wrap ? '0 : r_idx + 1'b1;
        r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
        r_phase <= r_phase ^ w_last;
      end
      if (w_wrap) begin
        r_digits   <= digits_bcd;
        r_dp       <= dp_in;
        r_blink    <= blink_en;
        r_blank_lz <= blank_lz;
      end
    end
  end
  // mark digits that sit inside the run of leading zeros; digit 0 always stays visible
  always_comb begin
    w_run = 1'b1;
    w_lz  = '0;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      w_run   = w_run & (r_digits[4*k +: 4] == 4'd0);
      w_lz[k] = w_run;
    end
  end
  assign w_digit = r_digits[{r_idx, 2'b00} +: 4];
  assign w_dark  = (r_blank_lz & w_lz[r_idx]) | (r_phase & r_blink[r_idx]);
  // outputs refresh one cycle after each tick so the display is dark from reset until the first tick
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      an         <= '1;
      seg        <= SEG_OFF;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= r_wrap;
      if (r_upd) begin
        an  <= w_dark ? '1 : ~(NUM_DIGITS'(1) << r_idx);
        seg <= w_dark ? SEG_OFF : bcd_to_seg(w_digit);
        dp  <= w_dark | ~r_dp[r_idx];
      end
    end
  end
endmodule

// File: tb/tb_seven_seg_scan.sv
// tb_seven_seg_scan: randomized self-checking bench against a digit-level display model
module tb_seven_seg_scan;
  localparam int N  = 4;
  localparam int BT = 3;
  logic clk_in = 1'b0, rst_n = 1'b0, scan_clk = 1'b0, blank_lz = 1'b0;
  logic [15:0] digits_bcd = '0;
  logic [3:0] dp_in = '0, blink_en = '0, an;
  logic [6:0] seg;
  logic dp, frame_done;
  int n_tests = 0, n_fail = 0;
  int m_idx, m_cnt;
  bit m_phase, sblz;
  int sd [N];
  bit sdp [N], sbl [N];
  logic [3:0] e_an;
  logic [6:0] e_seg;
  logic e_dp, e_fd;
  logic [6:0] glyph_on [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  always #5 clk_in = ~clk_in;

  seven_seg_scan #(.NUM_DIGITS(N), .BLINK_TICKS(BT)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .scan_clk(scan_clk), .digits_bcd(digits_bcd),
    .dp_in(dp_in), .blank_lz(blank_lz), .blink_en(blink_en),
    .an(an), .seg(seg), .dp(dp), .frame_done(frame_done)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic void model_reset();
    m_idx = N - 1; m_cnt = 0; m_phase = 0; sblz = 0;
    for (int i = 0; i < N; i++) begin sd[i] = 0; sdp[i] = 0; sbl[i] = 0; end
    e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
  endfunction

  function automatic void model_tick();
    bit dark, allz;
    m_idx = (m_idx + 1) % N;
    e_fd = (m_idx == 0);
    if (e_fd) begin
      for (int i = 0; i < N; i++) begin
        sd[i] = int'(digits_bcd[4*i +: 4]); sdp[i] = dp_in[i]; sbl[i] = blink_en[i];
      end
      sblz = blank_lz;
    end
    m_cnt++;
    if (m_cnt == BT) begin m_cnt = 0; m_phase = !m_phase; end
    dark = m_phase && sbl[m_idx];
    if (sblz && m_idx != 0) begin
      allz = 1;
      for (int j = m_idx; j < N; j++) if (sd[j] != 0) allz = 0;
      dark = dark || allz;
    end
    if (dark) begin
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
    end else begin
      e_an = 4'hF; e_an[m_idx] = 1'b0;
      e_seg = sd[m_idx] < 10 ? ~glyph_on[sd[m_idx]] : ~7'h40;
      e_dp = !sdp[m_idx];
    end
  endfunction

  // one scan_clk rising edge; returns just after the edge where outputs change
  task automatic do_tick();
    @(negedge clk_in) scan_clk = 1'b0;
    repeat (3) @(negedge clk_in);
    scan_clk = 1'b1;
    repeat (4) @(posedge clk_in);
    #1;
    model_tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    model_reset();
    n_tests++;
    if ({an, seg, dp, frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL reset: an=%b seg=%h dp=%b fd=%b want an=1111 seg=7f dp=1 fd=0", an, seg, dp, frame_done);
    end
    @(negedge clk_in) rst_n = 1'b1;
  endtask

  task automatic test_basic();
    digits_bcd = 16'h1234; blank_lz = 0; dp_in = 0; blink_en = 0;
    for (int t = 0; t < 4; t++) begin
      do_tick();
      n_tests++;
      if ({an, seg, dp, frame_done} !== {e_an, e_seg, e_dp, e_fd}) begin
        n_fail++;
        $display("FAIL basic t%0d: got an=%b seg=%h dp=%b fd=%b want an=%b seg=%h dp=%b fd=%b",
                 t, an, seg, dp, frame_done, e_an, e_seg, e_dp, e_fd);
      end
    end
  endtask

  task automatic test_leading_zero();
    blank_lz = 1;
    for (int t = 0; t < 16; t++) begin
      digits_bcd = t < 8 ? 16'h0042 : (t < 12 ? 16'h0000 : 16'h0100);
      do_tick();
      n_tests++;
      if ({an, seg, dp, frame_done} !== {e_an, e_seg, e_dp, e_fd}) begin
        n_fail++;
        $display("FAIL lz t%0d: got an=%b seg=%h dp=%b fd=%b want an=%b seg=%h dp=%b fd=%b",
                 t, an, seg, dp, frame_done, e_an, e_seg, e_dp, e_fd);
      end
    end
    blank_lz = 0;
  endtask

  task automatic test_snapshot();
    digits_bcd = 16'h1111;
    for (int t = 0; t < 12; t++) begin
      if (t == 5) digits_bcd = 16'h9999;
      do_tick();
      n_tests++;
      if ({an, seg, dp, frame_done} !== {e_an, e_seg, e_dp, e_fd}) begin
        n_fail++;
        $display("FAIL snapshot t%0d: got an=%b seg=%h fd=%b want an=%b seg=%h fd=%b",
                 t, an, seg, frame_done, e_an, e_seg, e_fd);
      end
    end
  endtask

  task automatic test_blink();
    digits_bcd = 16'h5678; blink_en = 4'b0001;
    for (int t = 0; t < 24; t++) begin
      if (t == 12) blink_en = 4'($urandom);
      do_tick();
      n_tests++;
      if ({an, seg, dp} !== {e_an, e_seg, e_dp}) begin
        n_fail++;
        $display("FAIL blink t%0d: got an=%b seg=%h dp=%b want an=%b seg=%h dp=%b",
                 t, an, seg, dp, e_an, e_seg, e_dp);
      end
    end
    blink_en = 0;
  endtask

  task automatic test_dash_dp();
    digits_bcd = 16'hFA3B; dp_in = 4'b0101;
    for (int t = 0; t < 8; t++) begin
      do_tick();
      n_tests++;
      if ({an, seg, dp} !== {e_an, e_seg, e_dp}) begin
        n_fail++;
        $display("FAIL dash t%0d: got an=%b seg=%h dp=%b want an=%b seg=%h dp=%b",
                 t, an, seg, dp, e_an, e_seg, e_dp);
      end
    end
    dp_in = 0;
  endtask

  task automatic test_random();
    for (int t = 0; t < 48; t++) begin
      if ($urandom_range(0, 2) == 0) begin
        digits_bcd = 16'($urandom); dp_in = 4'($urandom); blink_en = 4'($urandom);
        blank_lz = 1'($urandom);
        if ($urandom_range(0, 1) == 1) digits_bcd[15:8] = 8'h00;
      end
      do_tick();
      n_tests++;
      if ({an, seg, dp, frame_done} !== {e_an, e_seg, e_dp, e_fd}) begin
        n_fail++;
        $display("FAIL random t%0d: got an=%b seg=%h dp=%b fd=%b want an=%b seg=%h dp=%b fd=%b",
                 t, an, seg, dp, frame_done, e_an, e_seg, e_dp, e_fd);
      end
    end
  endtask

  task automatic test_hold();
    do_tick();
    repeat (30) @(posedge clk_in);
    #1;
    n_tests++;
    if ({an, seg, dp, frame_done} !== {e_an, e_seg, e_dp, 1'b0}) begin
      n_fail++;
      $display("FAIL hold_high: got an=%b seg=%h dp=%b fd=%b want an=%b seg=%h dp=%b fd=0",
               an, seg, dp, frame_done, e_an, e_seg, e_dp);
    end
    @(negedge clk_in) scan_clk = 1'b0;
    repeat (30) @(posedge clk_in);
    #1;
    n_tests++;
    if ({an, seg, dp, frame_done} !== {e_an, e_seg, e_dp, 1'b0}) begin
      n_fail++;
      $display("FAIL hold_low: got an=%b seg=%h dp=%b fd=%b want an=%b seg=%h dp=%b fd=0",
               an, seg, dp, frame_done, e_an, e_seg, e_dp);
    end
  endtask

  task automatic test_reset_mid();
    digits_bcd = 16'h4321; blank_lz = 0; blink_en = 0; dp_in = 4'b0001;
    do_tick();
    do_tick();
    @(negedge clk_in) begin scan_clk = 1'b0; rst_n = 1'b0; end
    @(posedge clk_in) #1;
    model_reset();
    n_tests++;
    if ({an, seg, dp, frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_mid_dark: got an=%b seg=%h dp=%b fd=%b want 1111 7f 1 0", an, seg, dp, frame_done);
    end
    @(negedge clk_in) rst_n = 1'b1;
    repeat (10) @(posedge clk_in);
    #1;
    n_tests++;
    if ({an, seg, dp} !== {4'hF, 7'h7F, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_mid_idle: got an=%b seg=%h dp=%b want 1111 7f 1", an, seg, dp);
    end
    @(negedge clk_in) scan_clk = 1'b1;
    repeat (3) @(posedge clk_in);
    #1;
    n_tests++;
    if ({an, frame_done} !== {4'hF, 1'b0}) begin
      n_fail++;
      $display("FAIL latency_e2: got an=%b fd=%b want an=1111 fd=0", an, frame_done);
    end
    @(posedge clk_in) #1;
    model_tick();
    n_tests++;
    if ({an, seg, dp, frame_done} !== {e_an, e_seg, e_dp, 1'b1}) begin
      n_fail++;
      $display("FAIL latency_e3: got an=%b seg=%h dp=%b fd=%b want an=%b seg=%h dp=%b fd=1",
               an, seg, dp, frame_done, e_an, e_seg, e_dp);
    end
    @(posedge clk_in) #1;
    n_tests++;
    if (frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL fd_pulse: got fd=%b want 0", frame_done);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_leading_zero();
    test_snapshot();
    test_blink();
    test_dash_dp();
    test_hold();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
